// File: rtl/game_pkg.sv
// ============================================================================
// Module  : game_pkg
// Brief   : Shared game state type and active-low 7-segment digit codes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  // Bit0 = segment a ... bit6 = segment g; a 0 lights the segment.
  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_encoder.sv
// ============================================================================
// Module  : seg7_encoder
// Brief   : Combinational BCD digit to active-low 7-segment code.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_encoder
  import game_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] segment
);

  always_comb begin
    segment = seg_encode(digit);
  end

endmodule

`default_nettype wire

// File: rtl/game_timer_score.sv
// ============================================================================
// Module  : game_timer_score
// Brief   : Game state machine, countdown timer and saturating score with
//           registered 7-segment outputs, clocked by the pixel clock.
//           Optional macro GAME_OVER_BLINK_EN blinks the time digit in OVER.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module game_timer_score
  import game_pkg::*;
#(
  parameter int CLK_HZ       = 25000000,
  parameter int GAME_SECONDS = 9,
  parameter int SCORE_MAX    = 9
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       start_n,
  input  logic       score_pulse,
  output logic [6:0] time_segment,
  output logic [6:0] score_segment,
  output logic       running,
  output logic       game_over
);

  localparam int             PW         = $clog2(CLK_HZ);
  localparam logic [PW-1:0]  PRE_LAST   = PW'(CLK_HZ - 1);
  localparam logic [3:0]     GAME_DIGIT = 4'(GAME_SECONDS);
  localparam logic [3:0]     SCORE_TOP  = 4'(SCORE_MAX);

  state_t          state, state_next;
  logic [PW-1:0]   prescaler, prescaler_next;
  logic [3:0]      time_digit, time_next;
  logic [3:0]      score_digit, score_next;
  logic            sync1, sync2, sync3, start_evt;
  logic            wrap;
  logic            blank_show;
  logic [6:0]      time_enc, score_enc;

  // start_n is asynchronous: two sync flops, a history flop, and a
  // registered falling-edge strobe.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      sync3     <= 1'b1;
      start_evt <= 1'b0;
    end else begin
      sync1     <= start_n;
      sync2     <= sync1;
      sync3     <= sync2;
      start_evt <= sync3 & ~sync2;
    end
  end

  assign wrap = (prescaler == PRE_LAST);

  always_comb begin
    state_next     = state;
    prescaler_next = prescaler;
    time_next      = time_digit;
    score_next     = score_digit;
    case (state)
      IDLE: begin
        if (start_evt) begin
          state_next     = RUN;
          prescaler_next = '0;
          time_next      = GAME_DIGIT;
          score_next     = 4'd0;
        end
      end
      RUN: begin
        prescaler_next = wrap ? '0 : prescaler + 1'b1;
        if (wrap) begin
          if (time_digit <= 4'd1) begin
            time_next  = 4'd0;
            state_next = OVER;
          end else begin
            time_next = time_digit - 4'd1;
          end
        end
        if (score_pulse && (score_digit < SCORE_TOP)) begin
          score_next = score_digit + 4'd1;
        end
      end
      OVER: begin
`ifdef GAME_OVER_BLINK_EN
        prescaler_next = wrap ? '0 : prescaler + 1'b1;
`endif
        if (start_evt) begin
          state_next     = RUN;
          prescaler_next = '0;
          time_next      = GAME_DIGIT;
          score_next     = 4'd0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state       <= IDLE;
      prescaler   <= '0;
      time_digit  <= GAME_DIGIT;
      score_digit <= 4'd0;
    end else begin
      state       <= state_next;
      prescaler   <= prescaler_next;
      time_digit  <= time_next;
      score_digit <= score_next;
    end
  end

`ifdef GAME_OVER_BLINK_EN
  logic blank, blank_next;

  // Cleared whenever the next state leaves OVER, so RUN shows a steady digit
  // from the same edge; toggles on each wrap while staying in OVER.
  always_comb begin
    blank_next = 1'b0;
    if (state_next == OVER) begin
      blank_next = (state == OVER && wrap) ? ~blank : blank;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      blank <= 1'b0;
    end else begin
      blank <= blank_next;
    end
  end

  assign blank_show = blank_next;
`else
  assign blank_show = 1'b0;
`endif

  seg7_encoder u_time_enc (
    .digit   (time_digit),
    .segment (time_enc)
  );

  seg7_encoder u_score_enc (
    .digit   (score_digit),
    .segment (score_enc)
  );

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      time_segment  <= seg_encode(GAME_DIGIT);
      score_segment <= SEG_0;
      running       <= 1'b0;
      game_over     <= 1'b0;
    end else begin
      time_segment  <= blank_show ? SEG_BLANK : time_enc;
      score_segment <= score_enc;
      running       <= (state_next == RUN);
      game_over     <= (state_next == OVER);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_game_timer_score.sv
// ============================================================================
// Module  : tb_game_timer_score
// Brief   : Randomized and directed bench for game_timer_score against a
//           cycle-level behavioural model of the game rules.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_timer_score;

  localparam int CLK_HZ       = 10;
  localparam int GAME_SECONDS = 3;
  localparam int SCORE_MAX    = 9;

  logic       vga_clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_n = 1'b1;
  logic       score_pulse = 1'b0;
  logic [6:0] time_segment, score_segment;
  logic       running, game_over;

  int errors = 0;
  int checks = 0;

  game_timer_score #(
    .CLK_HZ       (CLK_HZ),
    .GAME_SECONDS (GAME_SECONDS),
    .SCORE_MAX    (SCORE_MAX)
  ) dut (
    .vga_clk       (vga_clk),
    .reset         (reset),
    .start_n       (start_n),
    .score_pulse   (score_pulse),
    .time_segment  (time_segment),
    .score_segment (score_segment),
    .running       (running),
    .game_over     (game_over)
  );

  always #5 vga_clk = ~vga_clk;

  logic [6:0] codes [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic logic [6:0] enc(input int d);
    if (d >= 0 && d <= 9) return codes[d];
    return 7'h7F;
  endfunction

  // Model: 0 = idle, 1 = playing, 2 = game over.
  int   m_state = 0, m_time = GAME_SECONDS, m_score = 0, m_pre = 0;
  bit   m_blank = 0;
  bit   hist [1:4] = '{1, 1, 1, 1};
  logic [6:0] e_time_seg, e_score_seg;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic new_game();
    m_state = 1; m_time = GAME_SECONDS; m_score = 0; m_pre = 0; m_blank = 0;
  endtask

  // One rising edge of the game rules, using the inputs present at that edge.
  task automatic model_edge();
    int  pt = m_time;
    int  ps = m_score;
    bit  evt = hist[4] && !hist[3];
    bit  wrap = (m_pre == CLK_HZ - 1);
    if (reset) begin
      m_state = 0; m_time = GAME_SECONDS; m_score = 0; m_pre = 0; m_blank = 0;
      for (int i = 1; i <= 4; i++) hist[i] = 1;
      e_time_seg  = enc(GAME_SECONDS);
      e_score_seg = enc(0);
    end else begin
      case (m_state)
        0: if (evt) new_game();
        1: begin
          m_pre = wrap ? 0 : m_pre + 1;
          if (score_pulse && m_score < SCORE_MAX) m_score++;
          if (wrap) begin
            m_time--;
            if (m_time == 0) m_state = 2;
          end
        end
        default: begin
`ifdef GAME_OVER_BLINK_EN
          m_pre = wrap ? 0 : m_pre + 1;
          if (wrap) m_blank = !m_blank;
`endif
          if (evt) new_game();
        end
      endcase
      hist[4] = hist[3]; hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = start_n;
      e_time_seg  = (m_state == 2 && m_blank) ? 7'h7F : enc(pt);
      e_score_seg = enc(ps);
    end
  endtask

  task automatic step();
    @(posedge vga_clk);
    model_edge();
    #1;
    check("time_seg", 32'(time_segment), 32'(e_time_seg));
    check("score_seg", 32'(score_segment), 32'(e_score_seg));
    check("running", 32'(running), 32'(m_state == 1));
    check("game_over", 32'(game_over), 32'(m_state == 2));
  endtask

  task automatic press_start();
    start_n = 1'b0;
    repeat (4) step();
    start_n = 1'b1;
  endtask

  initial begin
    int n;

    // Reset state
    reset = 1'b1;
    step(); step();
    check("rst_time", 32'(time_segment), 32'h30);
    check("rst_score", 32'(score_segment), 32'h40);
    check("rst_running", 32'(running), 32'd0);
    check("rst_over", 32'(game_over), 32'd0);
    reset = 1'b0;
    step();

    // Start latency: running rises on the fourth edge after the pin falls
    start_n = 1'b0;
    step(); step(); step();
    check("start_lat3", 32'(running), 32'd0);
    step();
    check("start_lat4", 32'(running), 32'd1);
    start_n = 1'b1;

    // Saturation: 12 hits in a 3-second game
    score_pulse = 1'b1;
    repeat (12) step();
    score_pulse = 1'b0;
    step();
    check("score_sat", 32'(score_segment), 32'h10);

    n = 0;
    while (!game_over && n < 100) begin step(); n++; end
    check("reach_over", 32'(game_over), 32'd1);
    score_pulse = 1'b1;
    repeat (5) step();
    score_pulse = 1'b0;
    step();
    check("over_score_hold", 32'(score_segment), 32'h10);

    // Restart from OVER
    press_start();
    check("restart_run", 32'(running), 32'd1);
    step();
    check("restart_time", 32'(time_segment), 32'h30);
    check("restart_score", 32'(score_segment), 32'h40);

    // Start bounce during RUN is ignored
    for (int i = 0; i < 8; i++) begin
      start_n = i[0];
      step();
    end
    start_n = 1'b1;
    check("no_restart", 32'(m_state == 1 && m_pre != 0), 32'd1);

    // Final-tick coincidence with score 4
    score_pulse = 1'b1;
    repeat (4) step();
    score_pulse = 1'b0;
    n = 0;
    while (!(m_state == 1 && m_time == 1 && m_pre == CLK_HZ - 1) && n < 100) begin
      step(); n++;
    end
    check("final_tick_found", 32'(n < 100), 32'd1);
    score_pulse = 1'b1;
    step();
    score_pulse = 1'b0;
    check("final_over", 32'(game_over), 32'd1);
    step();
    check("final_score", 32'(score_segment), 32'h12);
    repeat (25) step();

    // Reset mid-RUN at time 2
    press_start();
    n = 0;
    while (m_time != 2 && n < 100) begin step(); n++; end
    reset = 1'b1;
    step();
    check("midrst_running", 32'(running), 32'd0);
    check("midrst_time", 32'(time_segment), 32'h30);
    check("midrst_score", 32'(score_segment), 32'h40);
    reset = 1'b0;

    // Randomized play
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 599) == 0);
      start_n     = ($urandom_range(0, 24) != 0);
      score_pulse = ($urandom_range(0, 2) == 0) ||
                    (m_state == 1 && m_time == 1 && m_pre == CLK_HZ - 1);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
